// File: rtl/apb_sp_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_sp_ram_ctrl_if
// Description : APB3 bus bundle between the peripheral interconnect (master)
//               and the SRAM controller (slave).
// Ports       : PADDR/PWDATA/PWRITE/PSEL/PENABLE  requester -> completer
//               PRDATA/PREADY/PSLVERR             completer -> requester
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_sp_ram_ctrl_if;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/apb_sp_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb_sp_ram_ctrl
// Description : APB3 completer in front of a single-port SRAM (one-cycle read
//               latency). Writes complete with no wait state, reads take one
//               wait state, misaligned accesses get PSLVERR. A clear engine
//               zero-fills the whole array on request while stalling APB.
// Ports       : clk, rst_n        clock, asynchronous active-low reset
//               apb               APB3 slave modport
//               clr_req_i         pulse to start a zero-fill
//               clr_busy_o        high while the zero-fill runs
//               clr_done_o        one-cycle pulse after the last clear write
//               ram_*             SRAM request side / read data
// Revision    : 1.0 - initial release
// ============================================================================
module apb_sp_ram_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  apb_sp_ram_ctrl_if.slave           apb,
  input  wire logic                  clr_req_i,
  output logic                       clr_busy_o,
  output logic                       clr_done_o,
  output logic                       ram_en_o,
  output logic                       ram_we_o,
  output logic [3:0]                 ram_be_o,
  output logic [ADDR_WIDTH-1:0]      ram_addr_o,
  output logic [DATA_WIDTH-1:0]      ram_wdata_o,
  input  wire logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int CW = ADDR_WIDTH - 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_CLEAR   = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = '1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;

  logic w_access;
  logic w_misaligned;
  logic w_unused_paddr_hi;

  assign w_access     = apb.PSEL & apb.PENABLE;
  assign w_misaligned = |apb.PADDR[1:0];
  // Address bits above the RAM window are ignored by design.
  assign w_unused_paddr_hi = ^apb.PADDR[31:ADDR_WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    // Requests arriving while the engine runs are absorbed.
    pend_d  = pend_q | (clr_req_i & (state_q != ST_CLEAR));

    apb.PREADY  = 1'b0;
    apb.PSLVERR = 1'b0;
    apb.PRDATA  = '0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;

    case (state_q)
      ST_IDLE: begin
        if (w_access) begin
          // APB has priority over a pending clear.
          if (w_misaligned) begin
            apb.PREADY  = 1'b1;
            apb.PSLVERR = 1'b1;
          end else if (apb.PWRITE) begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_be_o    = 4'hF;
            ram_addr_o  = {apb.PADDR[ADDR_WIDTH-1:2], 2'b00};
            ram_wdata_o = apb.PWDATA;
            apb.PREADY  = 1'b1;
          end else begin
            ram_en_o   = 1'b1;
            ram_addr_o = {apb.PADDR[ADDR_WIDTH-1:2], 2'b00};
            state_d    = ST_RD_WAIT;
          end
        end else if (pend_q) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end

      ST_RD_WAIT: begin
        apb.PRDATA = ram_rdata_i;
        apb.PREADY = 1'b1;
        state_d    = ST_IDLE;
      end

      ST_CLEAR: begin
        ram_en_o   = 1'b1;
        ram_we_o   = 1'b1;
        ram_be_o   = 4'hF;
        ram_addr_o = {cnt_q, 2'b00};
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are combinational from APB inputs, so force them quiet while
    // reset is held to keep the RAM untouched.
    if (!rst_n) begin
      apb.PREADY  = 1'b0;
      apb.PSLVERR = 1'b0;
      apb.PRDATA  = '0;
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_be_o    = 4'h0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  assign clr_busy_o = (state_q == ST_CLEAR);
  assign clr_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_sp_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_sp_ram_ctrl
// Description : Scoreboard bench for apb_sp_ram_ctrl with a behavioural SRAM
//               and a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_sp_ram_ctrl;
  localparam int AW = 14;
  localparam int NW = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_sp_ram_ctrl_if apb ();

  logic          clr_req;
  logic          clr_busy, clr_done;
  logic          ram_en, ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;

  apb_sp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .apb         (apb),
    .clr_req_i   (clr_req),
    .clr_busy_o  (clr_busy),
    .clr_done_o  (clr_done),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  // Behavioural single-port SRAM, one-cycle read latency.
  logic [31:0] ram [NW] = '{default: '0};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) ram[ram_addr[AW-1:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram[ram_addr[AW-1:2]];
      end
    end
  end

  // Reference model: what each word should hold.
  logic [31:0] exp_mem [NW];

  typedef struct {
    logic [31:0] data;
    bit          err;
    int          waits;   // -1: transfer must have been stalled
  } exp_t;
  exp_t sbq[$];

  int vectors = 0;
  int errors  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  // APB response monitor.
  int mon_waits = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_waits = 0;
    end else if (apb.PSEL && apb.PENABLE) begin
      if (!apb.PREADY) begin
        mon_waits++;
      end else begin
        if (sbq.size() == 0) begin
          check("unexpected_response", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("prdata", apb.PRDATA, e.data);
          check("pslverr", apb.PSLVERR, e.err);
          if (e.waits >= 0) check("wait_states", mon_waits, e.waits);
          else              check("stalled_in_clear", mon_waits > 1, 1);
          check("ready_while_busy", clr_busy, 0);
        end
        mon_waits = 0;
      end
    end
  end

  // Clear-engine monitor: walk, length and done pulse.
  int busy_cnt = 0;
  int done_cnt = 0;
  bit walk_ok  = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      walk_ok  = 1'b1;
    end else begin
      if (clr_done) done_cnt++;
      if (clr_busy) begin
        if (!(ram_en && ram_we && ram_be == 4'hF && ram_wdata == 32'h0 &&
              ram_addr == AW'(busy_cnt * 4)))
          walk_ok = 1'b0;
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        check("clr_busy_cycles", busy_cnt, NW);
        check("clr_addr_walk", walk_ok, 1);
        check("clr_done_pulse", clr_done, 1);
        busy_cnt = 0;
        walk_ok  = 1'b1;
      end
    end
  end

  function automatic void model_clear_all();
    for (int i = 0; i < NW; i++) exp_mem[i] = '0;
  endfunction

  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input bit stalled, input bit clr);
    exp_t e;
    int   n;
    int   idx;
    @(posedge clk); #2;
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = wr;
    apb.PADDR   = addr;
    apb.PWDATA  = data;
    @(posedge clk); #2;
    apb.PENABLE = 1'b1;
    clr_req     = clr;
    idx = int'(addr[AW-1:2]);
    if (addr[1:0] != 2'b00) begin
      e.data = '0; e.err = 1'b1; e.waits = 0;
    end else if (wr) begin
      exp_mem[idx] = data;
      e.data = '0; e.err = 1'b0; e.waits = 0;
    end else begin
      e.data = exp_mem[idx]; e.err = 1'b0; e.waits = 1;
    end
    if (stalled) e.waits = -1;
    sbq.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (apb.PREADY) break;
      n++;
      if (n > 6000) begin
        $display("FAIL apb_timeout: no PREADY after %0d cycles, required within 6000", n);
        $fatal(1, "bus hung");
      end
    end
    if (addr[1:0] != 2'b00) check("err_no_ram_en", ram_en, 0);
    @(posedge clk); #2;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    clr_req     = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #2 clr_req = 1'b1;
    @(posedge clk); #2 clr_req = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!clr_done && n < 6000);
    if (!clr_done) check("clr_done_timeout", n, 0);
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    bit          wr;

    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;
    clr_req = 1'b0;
    model_clear_all();

    // Reset with an access phase present: nothing may leak out.
    repeat (2) @(posedge clk);
    #2;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = 32'h10;
    #1;
    check("rst_pready", apb.PREADY, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_prdata", apb.PRDATA, 0);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;

    // Basic write/read and misaligned error.
    apb_xfer(1, 32'h10, 32'hDEADBEEF, 0, 0);
    apb_xfer(0, 32'h10, 32'h0, 0, 0);
    apb_xfer(0, 32'h13, 32'h0, 0, 0);
    apb_xfer(1, 32'h22, 32'h55AA55AA, 0, 0);

    // Fill, clear, read back.
    apb_xfer(1, 32'h0,    32'h11111111, 0, 0);
    apb_xfer(1, 32'h4,    32'h22222222, 0, 0);
    apb_xfer(1, 32'h3FFC, 32'h33333333, 0, 0);
    pulse_clear();
    model_clear_all();
    wait_done();
    apb_xfer(0, 32'h0,    32'h0, 0, 0);
    apb_xfer(0, 32'h4,    32'h0, 0, 0);
    apb_xfer(0, 32'h3FFC, 32'h0, 0, 0);

    // Read issued while the engine is running.
    apb_xfer(1, 32'h40, 32'hCAFEF00D, 0, 0);
    pulse_clear();
    model_clear_all();
    repeat (5) @(posedge clk);
    check("busy_during_clear", clr_busy, 1);
    apb_xfer(0, 32'h40, 32'h0, 1, 0);

    // Clear request coinciding with a write access phase.
    apb_xfer(1, 32'h20, 32'h12345678, 0, 1);
    model_clear_all();
    wait_done();
    apb_xfer(0, 32'h20, 32'h0, 0, 0);

    // Reset in the middle of a clear.
    apb_xfer(1, 32'h1F40, 32'hA5A5A5A5, 0, 0);
    apb_xfer(1, 32'h8,    32'h77777777, 0, 0);
    pulse_clear();
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(clr_busy && ram_addr == AW'(400)) && n < 6000);
      check("reach_word_100", clr_busy, 1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("abort_ram_en", ram_en, 0);
    check("abort_ram_we", ram_we, 0);
    check("abort_ram_addr", ram_addr, 0);
    check("abort_clr_busy", clr_busy, 0);
    for (int i = 0; i < 100; i++) exp_mem[i] = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    apb_xfer(1, 32'h8, 32'h0BADF00D, 0, 0);
    apb_xfer(0, 32'h8, 32'h0, 0, 0);
    apb_xfer(0, 32'h1F40, 32'h0, 0, 0);
    apb_xfer(0, 32'h190, 32'h0, 0, 0);

    // Randomised traffic, upper address bits scrambled.
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 3));
      a  = $urandom;
      a[AW-1:2] = (op == 1) ? 12'($urandom) : 12'($urandom_range(0, 31));
      a[1:0]    = (op == 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      wr = (op == 3) ? 1'($urandom) : (op < 2);
      apb_xfer(wr, a, $urandom, 0, 0);
    end

    repeat (4) @(posedge clk);
    check("clr_done_count", done_cnt, 3);
    check("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/apb_sp_ram_ctrl.md
# apb_sp_ram_ctrl

APB3 completer that fronts the single-port SRAM macro wrapper (`sp_ram`: en/addr/wdata/rdata/we/be, one-cycle read latency) and drives its request side. Converts APB transfers into single-cycle SRAM accesses, inserts the read wait state and rejects misaligned accesses. Contains a hardware clear engine that zero-fills the whole array on request while stalling APB. Sits between the peripheral APB interconnect and a data/scratch RAM instance.

## Interface
- `ADDR_WIDTH`, 14: RAM byte-address width; NUM_WORDS = 2^(ADDR_WIDTH-2)
- `DATA_WIDTH`, 32: data width; fixed at 32, with 4 byte lanes
- `clk` in 1: single clock, all logic rising-edge
- `rst_n` in 1: asynchronous, active-low reset
- `PADDR` in 32: APB address; bits [ADDR_WIDTH-1:0] used
- `PWDATA` in 32: APB write data
- `PWRITE` in 1: 1 = write
- `PSEL` in 1: completer select
- `PENABLE` in 1: access phase
- `PRDATA` out 32: read data; 0 when not returning a read
- `PREADY` out 1: transfer complete
- `PSLVERR` out 1: error response; valid only with PREADY
- `clr_req_i` in 1: single-cycle pulse to start a zero-fill
- `clr_busy_o` out 1: clear engine active
- `clr_done_o` out 1: one-cycle pulse after the last clear write
- `ram_en_o` out 1: RAM access enable, active-high
- `ram_we_o` out 1: 1 = write, 0 = read
- `ram_be_o` out 4: byte enables
- `ram_addr_o` out ADDR_WIDTH: byte address; bits [1:0] always 0
- `ram_wdata_o` out 32: RAM write data
- `ram_rdata_i` in 32: RAM read data, valid the cycle after a read enable

## Operation
- States: IDLE, RD_WAIT, CLEAR. Reset enters IDLE. On reset: clear counter = 0, clear-pending flag = 0, clr_busy_o = 0.
- The access phase is PSEL & PENABLE.
- IDLE, access phase, with PADDR[1:0] != 0:
  - PREADY = 1 and PSLVERR = 1 in the same cycle.
  - No RAM enable.
- IDLE, aligned write:
  - ram_en_o = 1, ram_we_o = 1, ram_be_o = 4'hF.
  - ram_addr_o = {PADDR[ADDR_WIDTH-1:2], 2'b00}, ram_wdata_o = PWDATA.
  - PREADY = 1 combinationally; stay in IDLE.
- IDLE, aligned read:
  - ram_en_o = 1, ram_we_o = 0, PREADY = 0.
  - Next state is RD_WAIT.
- RD_WAIT:
  - No RAM enable.
  - PRDATA = ram_rdata_i, PREADY = 1, PSLVERR = 0.
  - Next state is IDLE.
- clr_req_i in any state sets the clear-pending flag. A second request while pending or busy is absorbed.
- IDLE with the pending flag set and no access phase:
  - Enter CLEAR, counter = 0, clear the flag.
  - When an access phase and the pending flag coincide in IDLE, APB wins; CLEAR starts on the next IDLE cycle without an access phase.
- CLEAR:
  - Every cycle: ram_en_o = 1, ram_we_o = 1, ram_be_o = 4'hF, ram_wdata_o = 0, ram_addr_o = {counter, 2'b00}; counter increments.
  - After the write at counter = NUM_WORDS-1: counter wraps to 0, clr_done_o pulses for 1 cycle in the following IDLE cycle, next state IDLE.
  - clr_busy_o = 1 exactly while in CLEAR.
  - APB access phases see PREADY = 0 and are not serviced; they are serviced normally from IDLE afterwards.
- Defaults when not driven: PREADY = 0, PSLVERR = 0, PRDATA = 0, ram_en_o = 0, ram_we_o = 0, ram_be_o = 0, ram_addr_o = 0, ram_wdata_o = 0. All of these hold these values during reset.
- Counter width: ADDR_WIDTH-2 bits.
- Reset asserted mid-clear aborts the clear and returns to IDLE. RAM contents are then partially cleared, which is accepted.

## Timing
- Write: APB access phase is 1 cycle, no wait states; RAM write occurs on that cycle's edge.
- Read: 1 wait state. Access phase cycle 0 drives the RAM; cycle 1 returns PRDATA with PREADY.
- Error: 0 wait states.
- Clear: NUM_WORDS cycles in CLEAR (4096 at default), plus 0 to 2 cycles of start delay. clr_busy_o rises on the first clear write cycle.
- Back-to-back APB transfers need no idle cycles on the RAM side. The APB setup phase gives natural separation.
- RAM outputs are combinational from state, the counter and APB inputs. No registered path is added on the RAM request.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 and read 0x10:
  - The write completes with PREADY in the access cycle.
  - The read returns 0xDEADBEEF with exactly 1 wait state; PSLVERR = 0 on both.
- Read at PADDR = 0x13:
  - PREADY = 1 and PSLVERR = 1 in the access cycle.
  - ram_en_o is never asserted.
- Fill words 0, 1 and 4095 with nonzero data, then pulse clr_req_i:
  - clr_busy_o is high for exactly 4096 cycles, with ram_addr_o stepping 0x0 to 0x3FFC.
  - clr_done_o pulses once.
  - Reading back words 0, 1 and 4095 returns 0.
- Start an APB read during CLEAR:
  - PREADY stays low until CLEAR ends.
  - The read then returns 0 after its normal RD_WAIT cycle.
- Pulse clr_req_i in the same cycle as a write access phase to 0x20:
  - The write completes first.
  - CLEAR then starts, and 0x20 reads back 0 afterwards.
- Assert rst_n low at clear word 100:
  - All outputs return to their defaults asynchronously and the state is IDLE.
  - A post-reset write/read to 0x8 works.
  - Word 2000 retains its old data.
